// File: rtl/multicycle_control.sv
// Multicycle datapath controller. State register plus a decode block that
// derives the datapath controls from the current state, the opcode and mem_ready.
// Optional feature: define MC_JUMP_EN to include the JUMP state (opcode 000010).
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_RTYPEWB = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNC   = 2'b10;

    state_e state_q;
    state_e state_d;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; every control defaults to 0.
    always_comb begin
        state_d     = ST_IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUop       = ALU_ADD;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC load in the cycle the instruction word arrives.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = ST_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? ST_FETCH : ST_MEMWR;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALU_FUNC;
                state_d = ST_RTYPEWB;
            end
            ST_RTYPEWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALU_BRANCH;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = ST_FETCH;
            end
`ifdef MC_JUMP_EN
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = ST_FETCH;
            end
`endif
            // Unused encodings stay silent and recover through IDLE.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset-in-MEMRD sequence,
// and a randomized run against an instruction-level reference model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUop;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

`ifdef MC_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, ill;
        logic [1:0] pcsrc, srcb, aluop;
        logic [3:0] st;
    } outs_t;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .ALUop(ALUop), .state(state)
    );

    always #5 clk = ~clk;

    // Instruction classes the controller understands.
    function automatic bit is_mem(input logic [5:0] op);
        return (op == LW) || (op == SW);
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return is_mem(op) || (op == RT) || (op == BEQ) || (JEN && op == JMP);
    endfunction

    // Control word each phase of an instruction must present.
    function automatic outs_t exp_out(input int s, input logic [5:0] op, input logic mr);
        outs_t o;
        o    = '0;
        o.st = 4'(s);
        case (s)
            1: begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            2: begin o.srcb = 2'b11; o.ill = !known_op(op); end
            3: begin o.srca = 1; o.srcb = 2'b10; end
            4: begin o.mrd = 1; o.iord = 1; end
            5: begin o.rw = 1; o.m2r = 1; end
            6: begin o.mwr = 1; o.iord = 1; end
            7: begin o.srca = 1; o.aluop = 2'b10; end
            8: begin o.rw = 1; o.rdst = 1; end
            9: begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
            10: if (JEN) begin o.pcw = 1; o.pcsrc = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    // Phase sequencing of an instruction: fetch, decode, class-specific tail.
    function automatic int nxt(input int s, input logic [5:0] op, input logic mr);
        if (s == 0) return 1;
        if (s == 1) return mr ? 2 : 1;
        if (s == 2) begin
            if (is_mem(op)) return 3;
            if (op == RT)   return 7;
            if (op == BEQ)  return 9;
            if (JEN && op == JMP) return 10;
            return 1;
        end
        if (s == 3) return (op == LW) ? 4 : 6;
        if (s == 4) return mr ? 5 : 4;
        if (s == 6) return mr ? 1 : 6;
        if (s == 7) return 8;
        if (s == 5 || s == 8 || s == 9) return 1;
        if (s == 10) return JEN ? 1 : 0;
        return 0;
    endfunction

    function automatic outs_t got_out();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, illegal_op, PCSource, ALUSrcB, ALUop, state};
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h (state got %0d required %0d)",
                     name, got, exp, got.st, exp.st);
        end
    endtask

    // Drive at negedge, sample 1ns later, then let the rising edge pass.
    task automatic cycle(input logic r, input logic [5:0] op, input logic mr,
                         input bit do_chk, input int exp_st, input string name);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        #1;
        if (do_chk) check(name, got_out(), exp_out(exp_st, op, mr));
        @(posedge clk);
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic mr, input int st);
        vec_t v;
        v.r = r; v.op = op; v.mr = mr; v.st = 4'(st);
        vecs.push_back(v);
    endtask

    initial begin
        int mst;
        logic [5:0] op;
        logic r, mr;
        logic [5:0] pool [6];

        rst = 1'b1; opcode = '0; mem_ready = 1'b0;
        @(posedge clk);

        // Reset held, then released: IDLE, then FETCH with MemRead.
        add(1, RT, 0, 0);  add(0, RT, 0, 0);
        // lw with three fetch stalls, one MEMRD stall.
        add(0, LW, 0, 1);  add(0, LW, 0, 1);  add(0, LW, 0, 1);  add(0, LW, 1, 1);
        add(0, LW, 1, 2);  add(0, LW, 1, 3);  add(0, LW, 0, 4);  add(0, LW, 1, 4);
        add(0, LW, 1, 5);
        // sw with one MEMWR stall, then R-type.
        add(0, SW, 1, 1);  add(0, SW, 1, 2);  add(0, SW, 1, 3);  add(0, SW, 0, 6);
        add(0, SW, 1, 6);
        add(0, RT, 1, 1);  add(0, RT, 1, 2);  add(0, RT, 1, 7);  add(0, RT, 1, 8);
        // beq, mem_ready low in decode must be ignored.
        add(0, BEQ, 1, 1); add(0, BEQ, 0, 2); add(0, BEQ, 0, 9);
        // Illegal opcode pulse.
        add(0, BAD, 1, 1); add(0, BAD, 1, 2);
        // Jump opcode, build-dependent.
        add(0, JMP, 1, 1); add(0, JMP, 1, 2);
`ifdef MC_JUMP_EN
        add(0, JMP, 1, 10); add(0, JMP, 1, 1);
`else
        add(0, JMP, 1, 1);
`endif
        foreach (vecs[i])
            cycle(vecs[i].r, vecs[i].op, vecs[i].mr, 1'b1, int'(vecs[i].st),
                  $sformatf("vec%0d", i));

        // Reset while stalled in MEMRD.
        cycle(1, LW, 0, 1'b0, 0, "");
        cycle(0, LW, 1, 1'b1, 0, "rmr_idle");
        cycle(0, LW, 1, 1'b1, 1, "rmr_fetch");
        cycle(0, LW, 1, 1'b1, 2, "rmr_decode");
        cycle(0, LW, 1, 1'b1, 3, "rmr_memadr");
        cycle(0, LW, 0, 1'b1, 4, "rmr_memrd_wait");
        cycle(1, LW, 0, 1'b1, 4, "rmr_memrd_rst");
        cycle(0, LW, 0, 1'b1, 0, "rmr_after_rst");

        // Randomized run against the reference model.
        pool[0] = LW; pool[1] = SW; pool[2] = RT; pool[3] = BEQ; pool[4] = JMP; pool[5] = BAD;
        cycle(1, RT, 0, 1'b0, 0, "");
        mst = 0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
            mr = 1'($urandom);
            cycle(r, op, mr, 1'b1, mst, $sformatf("rand%0d", n));
            mst = r ? 0 : nxt(mst, op, mr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
